mem_bus_bridge: RTL and testbench



---
 rtl/mem_bus_bridge.sv | 184 ++++++++++++++++++
 tb/tb_mem_bus_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// Bridges the core memory-stage request port onto a word-wide valid/ready bus:
// lane strobes, store replication, load extension, misalignment/error/timeout faults.
module mem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  // Handshakes: a request moves when req_valid & req_ready at a rising edge;
  // a bus transfer completes when bus_valid & bus_ready at a rising edge.
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state, state_n;
  logic [2:0]  op_q, op_n;
  logic [1:0]  off_q, off_n;
  logic        write_q, write_n;
  logic [31:0] cnt_q, cnt_n;

  logic        req_ready_n, rsp_valid_n, rsp_fault_n;
  logic [31:0] rsp_rdata_n;
  logic        bus_valid_n, bus_write_n;
  logic [29:0] bus_addr_n;
  logic [3:0]  bus_wstrb_n;
  logic [31:0] bus_wdata_n;

  logic        req_bad;
  logic [3:0]  req_strb;
  logic [31:0] req_repl;
  logic [31:0] lane_word;
  logic [31:0] load_data;

  always_comb begin
    req_bad  = 1'b0;
    req_strb = 4'b1111;
    req_repl = req_wdata;
    case (req_op[1:0])
      2'b00: begin
        req_strb = 4'b0001 << req_addr[1:0];
        req_repl = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_bad  = req_addr[0];
        req_strb = 4'b0011 << req_addr[1:0];
        req_repl = {2{req_wdata[15:0]}};
      end
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0 before extension.
  assign lane_word = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    case (op_q[1:0])
      2'b00:   load_data = op_q[2] ? {24'd0, lane_word[7:0]}
                                   : {{24{lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_data = op_q[2] ? {16'd0, lane_word[15:0]}
                                   : {{16{lane_word[15]}}, lane_word[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_n     = state;
    op_n        = op_q;
    off_n       = off_q;
    write_n     = write_q;
    cnt_n       = cnt_q;
    req_ready_n = req_ready;
    rsp_valid_n = rsp_valid;
    rsp_fault_n = rsp_fault;
    rsp_rdata_n = rsp_rdata;
    bus_valid_n = bus_valid;
    bus_write_n = bus_write;
    bus_addr_n  = bus_addr;
    bus_wstrb_n = bus_wstrb;
    bus_wdata_n = bus_wdata;
    case (state)
      IDLE: begin
        req_ready_n = 1'b1;
        if (req_valid && req_ready) begin
          op_n        = req_op;
          off_n       = req_addr[1:0];
          write_n     = req_write;
          cnt_n       = 32'd0;
          req_ready_n = 1'b0;
          bus_write_n = req_write;
          bus_addr_n  = req_addr[31:2];
          bus_wstrb_n = req_strb;
          bus_wdata_n = req_repl;
          if (req_bad) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_fault_n = 1'b1;
            rsp_rdata_n = 32'd0;
          end else begin
            state_n     = BUS;
            bus_valid_n = 1'b1;
          end
        end
      end
      BUS: begin
        // A ready in the same cycle the counter expires wins over the timeout.
        if (bus_ready) begin
          state_n     = RESP;
          bus_valid_n = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_fault_n = bus_err;
          rsp_rdata_n = (bus_err || write_q) ? 32'd0 : load_data;
        end else if (TIMEOUT_CYCLES != 0 && (cnt_q + 32'd1) == TIMEOUT_CYCLES) begin
          state_n     = RESP;
          bus_valid_n = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_fault_n = 1'b1;
          rsp_rdata_n = 32'd0;
        end else begin
          cnt_n = cnt_q + 32'd1;
        end
      end
      RESP: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
        rsp_valid_n = 1'b0;
        rsp_fault_n = 1'b0;
        rsp_rdata_n = 32'd0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= 3'd0;
      off_q     <= 2'd0;
      write_q   <= 1'b0;
      cnt_q     <= 32'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= 32'd0;
      bus_valid <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= 30'd0;
      bus_wstrb <= 4'd0;
      bus_wdata <= 32'd0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      off_q     <= off_n;
      write_q   <= write_n;
      cnt_q     <= cnt_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_fault <= rsp_fault_n;
      rsp_rdata <= rsp_rdata_n;
      bus_valid <= bus_valid_n;
      bus_write <= bus_write_n;
      bus_addr  <= bus_addr_n;
      bus_wstrb <= bus_wstrb_n;
      bus_wdata <= bus_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge; inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        bus_valid, bus_write;
  logic [29:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready, bus_err;
  logic [31:0] bus_rdata;

  int compared = 0;
  int mismatched = 0;

  mem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for req_ready, then presents one request for a single edge (E0).
  task automatic issue(input logic w, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL issue_ready: req_ready=%b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_write = w;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  // Bus side: hold ready low for waits cycles, then answer with one ready cycle.
  task automatic finish_bus(input int waits, input logic [31:0] rd, input logic err);
    for (int i = 0; i < waits; i++) step();
    bus_ready = 1'b1;
    bus_rdata = rd;
    bus_err   = err;
    step();
    bus_ready = 1'b0;
    bus_rdata = 32'd0;
    bus_err   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    compared++;
    if ({req_ready, rsp_valid, bus_valid, rsp_fault} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_outputs: rdy/rsp/bus/flt=%b want 0000",
               {req_ready, rsp_valid, bus_valid, rsp_fault});
    end
    compared++;
    if (rsp_rdata !== 32'd0 || bus_wstrb !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_data: rdata=%h wstrb=%b want 0", rsp_rdata, bus_wstrb);
    end
    reset = 1'b0;
    step();
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_lw();
    issue(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    compared++;
    if (bus_valid !== 1'b1 || bus_write !== 1'b0 || bus_addr !== 30'h40 || bus_wstrb !== 4'b1111) begin
      mismatched++;
      $display("FAIL lw_bus: valid=%b write=%b addr=%h wstrb=%b want 1 0 40 1111",
               bus_valid, bus_write, bus_addr, bus_wstrb);
    end
    compared++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL lw_busy: req_ready=%b rsp_valid=%b want 0 0", req_ready, rsp_valid);
    end
    finish_bus(0, 32'hDEAD_BEEF, 1'b0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF || bus_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL lw_rsp: valid=%b fault=%b rdata=%h bus_valid=%b want 1 0 deadbeef 0",
               rsp_valid, rsp_fault, rsp_rdata, bus_valid);
    end
    step();
    compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL lw_pulse: rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_lb_lbu();
    issue(1'b0, 3'b000, 32'h0000_0103, 32'd0);
    compared++;
    if (bus_wstrb !== 4'b1000) begin
      mismatched++;
      $display("FAIL lb_wstrb: got %b want 1000", bus_wstrb);
    end
    finish_bus(0, 32'h8000_0000, 1'b0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_FF80) begin
      mismatched++;
      $display("FAIL lb_data: valid=%b rdata=%h want 1 ffffff80", rsp_valid, rsp_rdata);
    end
    step();
    issue(1'b0, 3'b100, 32'h0000_0103, 32'd0);
    finish_bus(0, 32'h8000_0000, 1'b0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0080) begin
      mismatched++;
      $display("FAIL lbu_data: valid=%b rdata=%h want 1 00000080", rsp_valid, rsp_rdata);
    end
    step();
    // LH at lane 2 with two wait states; bus outputs must hold across the waits.
    issue(1'b0, 3'b001, 32'h0000_0102, 32'd0);
    step();
    step();
    compared++;
    if (bus_valid !== 1'b1 || bus_wstrb !== 4'b1100 || bus_addr !== 30'h40 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL lh_hold: valid=%b wstrb=%b addr=%h rsp=%b want 1 1100 40 0",
               bus_valid, bus_wstrb, bus_addr, rsp_valid);
    end
    finish_bus(0, 32'h8001_0000, 1'b0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_8001) begin
      mismatched++;
      $display("FAIL lh_data: valid=%b rdata=%h want 1 ffff8001", rsp_valid, rsp_rdata);
    end
    step();
    issue(1'b0, 3'b101, 32'h0000_0000, 32'd0);
    finish_bus(0, 32'h1234_9ABC, 1'b0);
    compared++;
    if (rsp_rdata !== 32'h0000_9ABC) begin
      mismatched++;
      $display("FAIL lhu_data: rdata=%h want 00009abc", rsp_rdata);
    end
    step();
  endtask

  task automatic test_store();
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
    compared++;
    if (bus_valid !== 1'b1 || bus_write !== 1'b1 || bus_wstrb !== 4'b1100 ||
        bus_wdata !== 32'hABCD_ABCD || bus_addr !== 30'h80) begin
      mismatched++;
      $display("FAIL sh_bus: valid=%b write=%b wstrb=%b wdata=%h addr=%h want 1 1 1100 abcdabcd 80",
               bus_valid, bus_write, bus_wstrb, bus_wdata, bus_addr);
    end
    finish_bus(0, 32'hFFFF_FFFF, 1'b0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'd0) begin
      mismatched++;
      $display("FAIL sh_rsp: valid=%b fault=%b rdata=%h want 1 0 0", rsp_valid, rsp_fault, rsp_rdata);
    end
    step();
    issue(1'b1, 3'b000, 32'h0000_0001, 32'h1234_5678);
    compared++;
    if (bus_wstrb !== 4'b0010 || bus_wdata !== 32'h7878_7878) begin
      mismatched++;
      $display("FAIL sb_bus: wstrb=%b wdata=%h want 0010 78787878", bus_wstrb, bus_wdata);
    end
    finish_bus(0, 32'd0, 1'b0);
    step();
  endtask

  task automatic test_misalign();
    issue(1'b0, 3'b010, 32'h0000_0101, 32'd0);
    compared++;
    if (bus_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_rdata !== 32'd0) begin
      mismatched++;
      $display("FAIL lw_misalign: bus_valid=%b rsp=%b fault=%b rdata=%h want 0 1 1 0",
               bus_valid, rsp_valid, rsp_fault, rsp_rdata);
    end
    step();
    compared++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || bus_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL misalign_after: rsp=%b ready=%b bus_valid=%b want 0 1 0",
               rsp_valid, req_ready, bus_valid);
    end
    issue(1'b0, 3'b011, 32'h0000_0000, 32'd0);
    compared++;
    if (bus_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_fault !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_op: bus_valid=%b rsp=%b fault=%b want 0 1 1", bus_valid, rsp_valid, rsp_fault);
    end
    step();
    issue(1'b1, 3'b001, 32'h0000_0203, 32'hFFFF_FFFF);
    compared++;
    if (bus_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_fault !== 1'b1) begin
      mismatched++;
      $display("FAIL sh_misalign: bus_valid=%b rsp=%b fault=%b want 0 1 1", bus_valid, rsp_valid, rsp_fault);
    end
    step();
  endtask

  task automatic test_bus_err();
    issue(1'b0, 3'b010, 32'h0000_0010, 32'd0);
    finish_bus(0, 32'h0000_0055, 1'b1);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_rdata !== 32'd0) begin
      mismatched++;
      $display("FAIL bus_err: valid=%b fault=%b rdata=%h want 1 1 0", rsp_valid, rsp_fault, rsp_rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    int hi = 0;
    issue(1'b0, 3'b010, 32'h0000_0020, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (bus_valid === 1'b1 && rsp_valid === 1'b0) hi++;
      step();
    end
    compared++;
    if (hi !== 4) begin
      mismatched++;
      $display("FAIL timeout_valid_cycles: got %0d want 4", hi);
    end
    compared++;
    if (bus_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_rdata !== 32'd0) begin
      mismatched++;
      $display("FAIL timeout_rsp: bus_valid=%b rsp=%b fault=%b rdata=%h want 0 1 1 0",
               bus_valid, rsp_valid, rsp_fault, rsp_rdata);
    end
    step();
    // Ready in the fourth cycle coincides with the expiry and must complete normally.
    issue(1'b0, 3'b010, 32'h0000_0024, 32'd0);
    finish_bus(3, 32'hCAFE_F00D, 1'b0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin
      mismatched++;
      $display("FAIL timeout_edge: valid=%b fault=%b rdata=%h want 1 0 cafef00d",
               rsp_valid, rsp_fault, rsp_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_bus();
    issue(1'b0, 3'b010, 32'h0000_0040, 32'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    compared++;
    if (bus_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL midbus_reset: bus_valid=%b rsp=%b ready=%b want 0 0 0", bus_valid, rsp_valid, req_ready);
    end
    step();
    compared++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || bus_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midbus_recover: ready=%b rsp=%b bus_valid=%b want 1 0 0", req_ready, rsp_valid, bus_valid);
    end
    issue(1'b0, 3'b010, 32'h0000_0044, 32'd0);
    compared++;
    if (bus_addr !== 30'h11) begin
      mismatched++;
      $display("FAIL midbus_next_addr: got %h want 11", bus_addr);
    end
    finish_bus(0, 32'h1122_3344, 1'b0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0 || rsp_rdata !== 32'h1122_3344) begin
      mismatched++;
      $display("FAIL midbus_next_rsp: valid=%b fault=%b rdata=%h want 1 0 11223344",
               rsp_valid, rsp_fault, rsp_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 3'b010, 32'h0000_0080, 32'd0);
    finish_bus(0, 32'h0000_0001, 1'b0);
    // Request presented during RESP must not be taken until IDLE.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_op    = 3'b010;
    req_addr  = 32'h0000_0084;
    req_wdata = 32'd0;
    step();
    compared++;
    if (bus_valid !== 1'b0 || req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ignored_in_resp: bus_valid=%b ready=%b want 0 1", bus_valid, req_ready);
    end
    step();
    req_valid = 1'b0;
    compared++;
    if (bus_valid !== 1'b1 || bus_addr !== 30'h21 || req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_accept: bus_valid=%b addr=%h ready=%b want 1 21 0", bus_valid, bus_addr, req_ready);
    end
    finish_bus(0, 32'h0000_0002, 1'b0);
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0002) begin
      mismatched++;
      $display("FAIL b2b_rsp: valid=%b rdata=%h want 1 00000002", rsp_valid, rsp_rdata);
    end
    step();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    bus_ready = 1'b0;
    bus_rdata = 32'd0;
    bus_err   = 1'b0;
    #1;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_store();
    test_misalign();
    test_bus_err();
    test_timeout();
    test_reset_mid_bus();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
